// File: rtl/uart_buffer_pkg.sv
// Shared types and defaults for the UART message buffer.
package uart_buffer_pkg;

  typedef enum logic {
    DROP_NEWEST = 1'b0,
    DROP_OLDEST = 1'b1
  } ovf_mode_e;

  localparam int MSG_W_DEFAULT = 9;
  localparam int DEPTH_DEFAULT = 8;

endpackage

// File: rtl/message_dedup_filter.sv
// Idle filtering and burst-level repeat suppression in front of the message FIFO.
module message_dedup_filter
  import uart_buffer_pkg::*;
#(
  parameter int MSG_W     = MSG_W_DEFAULT,
  parameter int DEDUP     = 1,
  parameter int ZERO_IDLE = 1
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic [MSG_W-1:0] in_data,
  input  logic             in_valid,
  output logic             push,
  output logic [MSG_W-1:0] push_data
);

  logic [MSG_W-1:0] last_word_r;
  logic             last_valid_r;
  logic             cand_s;
  logic             repeat_s;

  // Candidate and duplicate detection for the current input word.
  always_comb begin
    cand_s    = in_valid && !((ZERO_IDLE != 0) && (in_data == {MSG_W{1'b0}}));
    repeat_s  = (DEDUP != 0) && last_valid_r && (in_data == last_word_r);
    push      = cand_s && !repeat_s;
    push_data = in_data;
  end

  // Remembers the last candidate; any idle cycle breaks the burst.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      last_word_r  <= {MSG_W{1'b0}};
      last_valid_r <= 1'b0;
    end else if (cand_s) begin
      last_word_r  <= in_data;
      last_valid_r <= 1'b1;
    end else begin
      last_valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_message_fifo.sv
// First-word-fall-through message queue with configurable overflow policy
// and a saturating overflow counter.
module uart_message_fifo
  import uart_buffer_pkg::*;
#(
  parameter int        MSG_W     = MSG_W_DEFAULT,
  parameter int        DEPTH     = DEPTH_DEFAULT,
  parameter int        DEDUP     = 1,
  parameter int        ZERO_IDLE = 1,
  parameter ovf_mode_e OVF_MODE  = DROP_NEWEST,
  parameter int        OVF_CNT_W = 8
) (
  input  logic                     clk_50,
  input  logic                     reset,
  input  logic [MSG_W-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     out_ready,
  input  logic                     clear_overflow,
  output logic [MSG_W-1:0]         out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow_flag,
  output logic [OVF_CNT_W-1:0]     overflow_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [MSG_W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r, count_nxt_s;
  logic                 ovf_flag_r, ovf_flag_nxt_s;
  logic [OVF_CNT_W-1:0] ovf_cnt_r, ovf_cnt_nxt_s;
  logic                 push_s, pop_s, write_s, adv_rd_s, ovf_evt_s;
  logic [MSG_W-1:0]     push_data_s;

  message_dedup_filter #(
    .MSG_W     (MSG_W),
    .DEDUP     (DEDUP),
    .ZERO_IDLE (ZERO_IDLE)
  ) u_filter (
    .clk_50    (clk_50),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .push      (push_s),
    .push_data (push_data_s)
  );

  assign empty     = (count_r == {CNT_W{1'b0}});
  assign full      = (count_r == CNT_W'(DEPTH));
  assign out_valid = !empty;
  assign count     = count_r;
  assign out_data  = empty ? {MSG_W{1'b0}} : mem_r[rd_ptr_r];
  assign overflow_flag  = ovf_flag_r;
  assign overflow_count = ovf_cnt_r;
  assign pop_s     = out_valid && out_ready;

  // Push/pop arbitration and overflow policy; pop is impossible while empty.
  always_comb begin
    write_s     = 1'b0;
    adv_rd_s    = 1'b0;
    ovf_evt_s   = 1'b0;
    count_nxt_s = count_r;
    if (push_s && pop_s) begin
      write_s  = 1'b1;
      adv_rd_s = 1'b1;
    end else if (pop_s) begin
      adv_rd_s    = 1'b1;
      count_nxt_s = count_r - CNT_W'(1);
    end else if (push_s) begin
      if (!full) begin
        write_s     = 1'b1;
        count_nxt_s = count_r + CNT_W'(1);
      end else if (OVF_MODE == DROP_OLDEST) begin
        write_s   = 1'b1;
        adv_rd_s  = 1'b1;
        ovf_evt_s = 1'b1;
      end else begin
        ovf_evt_s = 1'b1;
      end
    end else begin
      count_nxt_s = count_r;
    end

    // A same-cycle clear still records the concurrent event.
    if (clear_overflow) begin
      ovf_flag_nxt_s = ovf_evt_s;
      ovf_cnt_nxt_s  = ovf_evt_s ? OVF_CNT_W'(1) : {OVF_CNT_W{1'b0}};
    end else if (ovf_evt_s) begin
      ovf_flag_nxt_s = 1'b1;
      ovf_cnt_nxt_s  = (ovf_cnt_r == {OVF_CNT_W{1'b1}}) ? ovf_cnt_r : ovf_cnt_r + OVF_CNT_W'(1);
    end else begin
      ovf_flag_nxt_s = ovf_flag_r;
      ovf_cnt_nxt_s  = ovf_cnt_r;
    end
  end

  // Pointer, occupancy and overflow state registers.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      ovf_flag_r <= 1'b0;
      ovf_cnt_r  <= {OVF_CNT_W{1'b0}};
    end else begin
      if (write_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (adv_rd_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r    <= count_nxt_s;
      ovf_flag_r <= ovf_flag_nxt_s;
      ovf_cnt_r  <= ovf_cnt_nxt_s;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_50) begin
    if (write_s) mem_r[wr_ptr_r] <= push_data_s;
  end

endmodule

// File: tb/tb_uart_message_fifo.sv
// Scoreboard bench: drop-newest, drop-oldest and 2-bit-counter instances share stimulus.
module tb_uart_message_fifo;
  import uart_buffer_pkg::*;

  logic       clk_50 = 1'b0;
  logic       reset  = 1'b0;
  logic [8:0] in_data = 9'h000;
  logic       in_valid = 1'b0, out_ready = 1'b0, clear_overflow = 1'b0;

  logic [8:0] od_n, od_o, od_s;
  logic       ov_n, ov_o, ov_s, em_n, em_o, em_s, fu_n, fu_o, fu_s, fl_n, fl_o, fl_s;
  logic [3:0] cnt_n, cnt_o, cnt_s;
  logic [7:0] oc_n, oc_o;
  logic [1:0] oc_s;

  int errors = 0;
  int checks = 0;

  logic [8:0] qn[$];
  logic [8:0] qo[$];
  int         cn = 0, co = 0, cs = 0;
  logic       fn = 1'b0, fo = 1'b0;
  logic [8:0] lw = 9'h000;
  logic       lv = 1'b0;

  always #10 clk_50 = ~clk_50;

  uart_message_fifo #(.OVF_MODE(DROP_NEWEST)) u_new (
    .clk_50(clk_50), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_ready(out_ready), .clear_overflow(clear_overflow), .out_data(od_n),
    .out_valid(ov_n), .count(cnt_n), .empty(em_n), .full(fu_n),
    .overflow_flag(fl_n), .overflow_count(oc_n));

  uart_message_fifo #(.OVF_MODE(DROP_OLDEST)) u_old (
    .clk_50(clk_50), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_ready(out_ready), .clear_overflow(clear_overflow), .out_data(od_o),
    .out_valid(ov_o), .count(cnt_o), .empty(em_o), .full(fu_o),
    .overflow_flag(fl_o), .overflow_count(oc_o));

  uart_message_fifo #(.OVF_MODE(DROP_NEWEST), .OVF_CNT_W(2)) u_sat (
    .clk_50(clk_50), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .out_ready(out_ready), .clear_overflow(clear_overflow), .out_data(od_s),
    .out_valid(ov_s), .count(cnt_s), .empty(em_s), .full(fu_s),
    .overflow_flag(fl_s), .overflow_count(oc_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("new_count", 32'(cnt_n), 32'(qn.size()));
    check("new_valid", 32'(ov_n), 32'(qn.size() > 0));
    check("new_data", 32'(od_n), (qn.size() > 0) ? 32'(qn[0]) : 32'h0);
    check("new_full", 32'(fu_n), 32'(qn.size() == 8));
    check("new_ovf_cnt", 32'(oc_n), 32'(cn));
    check("new_ovf_flag", 32'(fl_n), 32'(fn));
    check("old_count", 32'(cnt_o), 32'(qo.size()));
    check("old_data", 32'(od_o), (qo.size() > 0) ? 32'(qo[0]) : 32'h0);
    check("old_ovf_cnt", 32'(oc_o), 32'(co));
    check("old_ovf_flag", 32'(fl_o), 32'(fo));
    check("sat_ovf_cnt", 32'(oc_s), 32'(cs));
  endtask

  // Reference behaviour of one clock edge for both overflow policies.
  task automatic model_edge(input logic [8:0] d, input logic v, input logic r, input logic c);
    logic cand, psh, pn, po, evn, evo;
    cand = v && (d != 9'h000);
    psh  = cand && !(lv && d == lw);
    if (cand) begin lw = d; lv = 1'b1; end else lv = 1'b0;
    pn = r && (qn.size() > 0);
    po = r && (qo.size() > 0);
    evn = 1'b0;
    evo = 1'b0;
    if (pn) void'(qn.pop_front());
    if (psh) begin
      if (pn || qn.size() < 8) qn.push_back(d); else evn = 1'b1;
    end
    if (po) void'(qo.pop_front());
    if (psh) begin
      if (!po && qo.size() == 8) begin void'(qo.pop_front()); evo = 1'b1; end
      qo.push_back(d);
    end
    if (c) begin
      cn = evn ? 1 : 0; cs = cn; co = evo ? 1 : 0; fn = evn; fo = evo;
    end else begin
      if (evn) begin cn = (cn == 255) ? 255 : cn + 1; cs = (cs == 3) ? 3 : cs + 1; fn = 1'b1; end
      if (evo) begin co = (co == 255) ? 255 : co + 1; fo = 1'b1; end
    end
  endtask

  // One cycle, entered and left on a falling edge.
  task automatic step(input logic [8:0] d, input logic v, input logic r, input logic c);
    in_data = d; in_valid = v; out_ready = r; clear_overflow = c;
    #1;
    if (r && qn.size() > 0) check("pop_new", 32'(od_n), 32'(qn[0]));
    if (r && qo.size() > 0) check("pop_old", 32'(od_o), 32'(qo[0]));
    model_edge(d, v, r, c);
    @(posedge clk_50);
    #1;
    check_state();
    @(negedge clk_50);
  endtask

  task automatic model_reset();
    qn.delete(); qo.delete();
    cn = 0; co = 0; cs = 0; fn = 1'b0; fo = 1'b0; lw = 9'h000; lv = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_50);
    check("reset_empty", 32'(em_n), 32'h1);
    check("reset_data", 32'(od_n), 32'h0);
    check_state();
    reset = 1'b1;

    // Ordered fill and drain.
    step(9'h101, 1'b1, 1'b0, 1'b0);
    step(9'h102, 1'b1, 1'b0, 1'b0);
    step(9'h103, 1'b1, 1'b0, 1'b0);
    check("fill3_count", 32'(cnt_n), 32'h3);
    check("fill3_head", 32'(od_n), 32'h101);
    repeat (3) step(9'h000, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 32'(em_n), 32'h1);
    step(9'h000, 1'b0, 1'b1, 1'b0);

    // Held level, idle gap, held again; then a zero word.
    repeat (5) step(9'h0A5, 1'b1, 1'b0, 1'b0);
    step(9'h000, 1'b0, 1'b0, 1'b0);
    repeat (2) step(9'h0A5, 1'b1, 1'b0, 1'b0);
    check("dedup_entries", 32'(cnt_n), 32'h2);
    step(9'h000, 1'b1, 1'b0, 1'b0);
    check("zero_idle", 32'(cnt_n), 32'h2);
    repeat (2) step(9'h000, 1'b0, 1'b1, 1'b0);

    // Ten distinct words into a depth-8 queue.
    for (int i = 1; i <= 10; i++) step(9'(i), 1'b1, 1'b0, 1'b0);
    check("newest_ovf", 32'(oc_n), 32'h2);
    check("newest_flag", 32'(fl_n), 32'h1);
    check("newest_head", 32'(od_n), 32'h1);
    check("oldest_ovf", 32'(oc_o), 32'h2);
    check("oldest_head", 32'(od_o), 32'h3);

    // Full with simultaneous push and pop.
    step(9'h00B, 1'b1, 1'b1, 1'b0);
    check("full_pp_count", 32'(cnt_n), 32'h8);
    check("full_pp_ovf", 32'(oc_n), 32'h2);

    // Overflow coinciding with clear, then drive the 2-bit counter into saturation.
    step(9'h00C, 1'b1, 1'b0, 1'b1);
    check("clear_ovf_cnt", 32'(oc_n), 32'h1);
    for (int i = 13; i <= 16; i++) step(9'(i), 1'b1, 1'b0, 1'b0);
    check("sat_at_max", 32'(oc_s), 32'h3);
    check("new_unsat", 32'(oc_n), 32'h5);
    step(9'h000, 1'b0, 1'b0, 1'b1);
    repeat (9) step(9'h000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle with five entries queued.
    for (int i = 1; i <= 5; i++) step(9'(9'h040 + i), 1'b1, 1'b0, 1'b0);
    check("pre_reset_count", 32'(cnt_n), 32'h5);
    #5;
    reset = 1'b0;
    #1;
    check("async_empty", 32'(em_n), 32'h1);
    check("async_valid", 32'(ov_n), 32'h0);
    check("async_count", 32'(cnt_n), 32'h0);
    check("async_count_old", 32'(cnt_o), 32'h0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk_50);
    reset = 1'b1;
    step(9'h1AB, 1'b1, 1'b0, 1'b0);
    check("post_reset_push", 32'(od_n), 32'h1AB);
    step(9'h000, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
